// File: rtl/hps_onchip_burst_memory.sv
// Avalon-MM on-chip RAM slave with incrementing read/write bursts and byte enables.
// Latency: read data returns READ_LATENCY (1 or 2) enabled cycles after the read issues.
// Backpressure: waitrequest in reset, while disabled (clken low / reset_req high), and while a read burst issues.
module hps_onchip_burst_memory #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 12,
    parameter int    DEPTH        = 4096,
    parameter int    BURST_WIDTH  = 4,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "HPS_onchip_memory.hex"
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [ADDR_WIDTH-1:0]     i_address,
    input  logic [BURST_WIDTH-1:0]    i_burstcount,
    input  logic [DATA_WIDTH/8-1:0]   i_byteenable,
    input  logic                      i_chipselect,
    input  logic                      i_read,
    input  logic                      i_write,
    input  logic [DATA_WIDTH-1:0]     i_writedata,
    input  logic                      i_clken,
    input  logic                      i_reset_req,
    output logic                      o_waitrequest,
    output logic [DATA_WIDTH-1:0]     o_readdata,
    output logic                      o_readdatavalid
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, RBURST = 2'd1, WBURST = 2'd2} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_nxt, w_nxt_nxt;
    logic [BURST_WIDTH-1:0]  r_rem, w_rem_nxt;
    logic                    w_en, w_wr_acc, w_rd_acc, w_mem_we, w_rd_issue;
    logic [ADDR_WIDTH-1:0]   w_first_addr, w_mem_addr;
    logic [BURST_WIDTH-1:0]  w_bc_eff;
    logic                    r_rdv;
    logic [DATA_WIDTH-1:0]   r_readdata;

    // Contents come from INIT_FILE at device configuration; reset never touches them.
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Burst address advance wraps at the end of the populated array, not the address space.
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (32'(a) == 32'(DEPTH - 1)) return '0;
        return a + ADDR_WIDTH'(1);
    endfunction

    assign w_en          = i_clken & ~i_reset_req;
    assign o_waitrequest = i_reset | ~w_en | (r_state == RBURST);
    // Write wins when read and write are both asserted; reads only start from IDLE.
    assign w_wr_acc      = i_chipselect & i_write & ~o_waitrequest;
    assign w_rd_acc      = i_chipselect & i_read & ~i_write & ~o_waitrequest & (r_state == IDLE);
    assign w_bc_eff      = (i_burstcount == '0) ? BURST_WIDTH'(1) : i_burstcount;
    assign w_first_addr  = ADDR_WIDTH'(32'(i_address) % 32'(DEPTH));

    // Next-state, burst bookkeeping and RAM port control.
    always_comb begin
        w_state_nxt = r_state;
        w_nxt_nxt   = r_nxt;
        w_rem_nxt   = r_rem;
        w_mem_we    = 1'b0;
        w_rd_issue  = 1'b0;
        w_mem_addr  = w_first_addr;
        case (r_state)
            IDLE: begin
                if (w_wr_acc || w_rd_acc) begin
                    w_mem_we   = w_wr_acc;
                    w_rd_issue = w_rd_acc;
                    if (w_bc_eff != BURST_WIDTH'(1)) begin
                        w_state_nxt = w_wr_acc ? WBURST : RBURST;
                        w_rem_nxt   = w_bc_eff - BURST_WIDTH'(1);
                        w_nxt_nxt   = f_next_addr(w_first_addr);
                    end
                end
            end
            RBURST: begin
                if (w_en && !i_reset) begin
                    w_rd_issue = 1'b1;
                    w_mem_addr = r_nxt;
                    w_nxt_nxt  = f_next_addr(r_nxt);
                    w_rem_nxt  = r_rem - BURST_WIDTH'(1);
                    if (r_rem == BURST_WIDTH'(1)) w_state_nxt = IDLE;
                end
            end
            WBURST: begin
                if (w_wr_acc) begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_nxt;
                    w_nxt_nxt  = f_next_addr(r_nxt);
                    w_rem_nxt  = r_rem - BURST_WIDTH'(1);
                    if (r_rem == BURST_WIDTH'(1)) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, burst address and remaining-beat registers; frozen while disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_nxt   <= '0;
            r_rem   <= '0;
        end else if (w_en) begin
            r_state <= w_state_nxt;
            r_nxt   <= w_nxt_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Byte-lane RAM write.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_byteenable[b]) r_mem[w_mem_addr][b*8 +: 8] <= i_writedata[b*8 +: 8];
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            // RAM output register doubles as the readdata register.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_rdv      <= 1'b0;
                    r_readdata <= '0;
                end else if (w_en) begin
                    r_rdv <= w_rd_issue;
                    if (w_rd_issue) r_readdata <= r_mem[w_mem_addr];
                end
            end
        end else begin : g_lat2
            logic                  r_v1;
            logic [DATA_WIDTH-1:0] r_ram_q;
            // RAM output register followed by an extra output stage.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_v1       <= 1'b0;
                    r_rdv      <= 1'b0;
                    r_readdata <= '0;
                end else if (w_en) begin
                    r_v1  <= w_rd_issue;
                    r_rdv <= r_v1;
                    if (w_rd_issue) r_ram_q <= r_mem[w_mem_addr];
                    if (r_v1) r_readdata <= r_ram_q;
                end
            end
        end
    endgenerate

    // A beat parked at the output during a stall is withheld until the enable returns.
    assign o_readdatavalid = r_rdv & w_en;
    assign o_readdata      = r_readdata;

endmodule

// File: tb/tb_hps_onchip_burst_memory.sv
// Bench for hps_onchip_burst_memory: latency-1 and latency-2 instances share one stimulus stream.
// A queue-based model predicts waitrequest and each returned beat; literal checks pin the model.
// Directed vectors only; every wait is a fixed cycle count.
module tb_hps_onchip_burst_memory;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst, cs, rd, wr, clken, reset_req;
    logic [11:0] address;
    logic [3:0]  burstcount, be;
    logic [31:0] wdata;
    logic        w1_wait, w1_rdv, w2_wait, w2_rdv;
    logic [31:0] w1_rdata, w2_rdata;

    hps_onchip_burst_memory #(.READ_LATENCY(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_address(address), .i_burstcount(burstcount),
        .i_byteenable(be), .i_chipselect(cs), .i_read(rd), .i_write(wr),
        .i_writedata(wdata), .i_clken(clken), .i_reset_req(reset_req),
        .o_waitrequest(w1_wait), .o_readdata(w1_rdata), .o_readdatavalid(w1_rdv));

    hps_onchip_burst_memory #(.READ_LATENCY(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_address(address), .i_burstcount(burstcount),
        .i_byteenable(be), .i_chipselect(cs), .i_read(rd), .i_write(wr),
        .i_writedata(wdata), .i_clken(clken), .i_reset_req(reset_req),
        .o_waitrequest(w2_wait), .o_readdata(w2_rdata), .o_readdatavalid(w2_rdv));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0, n_wait_hi = 0;

    typedef struct {int due; logic [31:0] data;} beat_t;
    typedef struct {logic [31:0] data; int cyc;} rx_t;

    // Model state: memory image, open burst, per-latency queues of outstanding beats.
    logic [31:0] m_mem [DEPTH];
    int          m_kind = 0;   // 0 none, 1 read burst, 2 write burst
    int          m_addr = 0, m_left = 0, n_en = 0;
    beat_t       q1[$], q2[$];
    rx_t         rx1[$], rx2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] at_data(input rx_t q[$], input int i);
        return (i < q.size()) ? q[i].data : 32'hFFFF_FFFF;
    endfunction
    function automatic int at_cyc(input rx_t q[$], input int i);
        return (i < q.size()) ? q[i].cyc : -1;
    endfunction

    always @(posedge clk) cyc++;

    // Model: applies the transfer rules on every clock edge.
    always @(posedge clk) begin
        int a, bc, ia;
        bit issue;
        issue = 1'b0;
        ia    = 0;
        if (rst) begin
            m_kind = 0;
            q1.delete();
            q2.delete();
        end else if (clken && !reset_req) begin
            if (q1.size() > 0 && q1[0].due == n_en) void'(q1.pop_front());
            if (q2.size() > 0 && q2[0].due == n_en) void'(q2.pop_front());
            bc = (burstcount == 0) ? 1 : int'(burstcount);
            if (m_kind == 1) begin
                issue = 1'b1; ia = m_addr;
                m_addr = (m_addr + 1) % DEPTH;
                m_left--;
                if (m_left == 0) m_kind = 0;
            end else if (cs && wr) begin
                a = (m_kind == 2) ? m_addr : int'(address) % DEPTH;
                for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][b*8 +: 8] = wdata[b*8 +: 8];
                if (m_kind == 2) begin
                    m_addr = (m_addr + 1) % DEPTH;
                    m_left--;
                    if (m_left == 0) m_kind = 0;
                end else if (bc > 1) begin
                    m_kind = 2; m_addr = (a + 1) % DEPTH; m_left = bc - 1;
                end
            end else if (cs && rd && m_kind == 0) begin
                a = int'(address) % DEPTH;
                issue = 1'b1; ia = a;
                if (bc > 1) begin
                    m_kind = 1; m_addr = (a + 1) % DEPTH; m_left = bc - 1;
                end
            end
            n_en++;
            if (issue) begin
                q1.push_back('{n_en, m_mem[ia]});
                q2.push_back('{n_en + 1, m_mem[ia]});
            end
        end
    end

    // Compare both instances against the model every cycle, and log delivered beats.
    always @(negedge clk) begin
        bit en, ev1, ev2;
        en  = clken && !reset_req;
        ev1 = en && q1.size() > 0 && q1[0].due == n_en;
        ev2 = en && q2.size() > 0 && q2[0].due == n_en;
        chk("waitrequest_L1", w1_wait, rst || !en || m_kind == 1);
        chk("waitrequest_L2", w2_wait, rst || !en || m_kind == 1);
        chk("readdatavalid_L1", w1_rdv, ev1);
        chk("readdatavalid_L2", w2_rdv, ev2);
        if (ev1) chk("readdata_L1", w1_rdata, q1[0].data);
        if (ev2) chk("readdata_L2", w2_rdata, q2[0].data);
        if (w1_rdv) rx1.push_back('{w1_rdata, cyc});
        if (w2_rdv) rx2.push_back('{w2_rdata, cyc});
        if (w1_wait && en && !rst) n_wait_hi++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        cs = 1'b0; rd = 1'b0; wr = 1'b0; burstcount = 4'd1;
    endtask

    task automatic wr_req(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b,
                          input logic [3:0] bc);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; address = a; wdata = d; be = b; burstcount = bc;
        tick();
        set_idle();
    endtask

    task automatic rd_req(input logic [11:0] a, input logic [3:0] bc, output int t);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; address = a; burstcount = bc;
        t = cyc;
        tick();
        set_idle();
    endtask

    initial begin
        int t;
        logic [31:0] wrap_exp [4];
        wrap_exp = '{32'hA000_0FFE, 32'hA000_0FFF, 32'hA000_0000, 32'hA000_0001};
        rst = 1'b1; clken = 1'b1; reset_req = 1'b0;
        address = '0; wdata = '0; be = 4'hF;
        set_idle();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_waitrequest_low", w1_wait, 1'b0);
        chk("reset_readdata_L1", w1_rdata, 32'h0);
        chk("reset_readdata_L2", w2_rdata, 32'h0);
        chk("reset_readdatavalid_L2", w2_rdv, 1'b0);

        // Single write then read; latency seen on each instance.
        wr_req(12'h010, 32'hDEAD_BEEF, 4'hF, 4'd1);
        rd_req(12'h010, 4'd1, t);
        repeat (3) tick();
        chk("single_data_L1", at_data(rx1, rx1.size() - 1), 32'hDEAD_BEEF);
        chk("single_lat_L1", at_cyc(rx1, rx1.size() - 1), t + 1);
        chk("single_lat_L2", at_cyc(rx2, rx2.size() - 1), t + 2);

        // Partial byte write, read issued the very next cycle.
        wr_req(12'h010, 32'h1122_3344, 4'b0101, 4'd1);
        rd_req(12'h010, 4'd1, t);
        repeat (3) tick();
        chk("byteen_data_L1", at_data(rx1, rx1.size() - 1), 32'hDE22_BE44);
        chk("byteen_data_L2", at_data(rx2, rx2.size() - 1), 32'hDE22_BE44);

        // Read and write together: only the write takes effect.
        rx1.delete();
        cs = 1'b1; rd = 1'b1; wr = 1'b1; address = 12'h300; wdata = 32'h5A5A_5A5A; be = 4'hF;
        tick();
        set_idle();
        repeat (3) tick();
        chk("rw_both_no_read", rx1.size(), 0);
        rd_req(12'h300, 4'd1, t);
        repeat (3) tick();
        chk("rw_both_write_won", at_data(rx1, 0), 32'h5A5A_5A5A);

        // Wrapping write burst preload, then wrapping read burst of 4.
        wr_req(12'hFFE, 32'hA000_0FFE, 4'hF, 4'd4);
        wr_req(12'hFFE, 32'hA000_0FFF, 4'hF, 4'd4);
        wr_req(12'hFFE, 32'hA000_0000, 4'hF, 4'd4);
        wr_req(12'hFFE, 32'hA000_0001, 4'hF, 4'd4);
        rx1.delete(); rx2.delete();
        n_wait_hi = 0;
        rd_req(12'hFFE, 4'd4, t);
        repeat (10) tick();
        chk("rburst_wait_cycles", n_wait_hi, 3);
        chk("rburst_count_L2", rx2.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("rburst_data_L2", at_data(rx2, i), wrap_exp[i]);
            chk("rburst_cyc_L2", at_cyc(rx2, i), t + 2 + i);
            chk("rburst_cyc_L1", at_cyc(rx1, i), t + 1 + i);
        end

        // Write burst with a two-cycle gap between beats 2 and 3; burstcount 0 reads one word.
        wr_req(12'h100, 32'hB000_0100, 4'hF, 4'd4);
        wr_req(12'h100, 32'hB000_0101, 4'hF, 4'd4);
        cs = 1'b1;
        repeat (2) tick();
        wr_req(12'h100, 32'hB000_0102, 4'hF, 4'd4);
        wr_req(12'h100, 32'hB000_0103, 4'hF, 4'd4);
        chk("model_mem_103", m_mem[12'h103], 32'hB000_0103);
        rx1.delete();
        rd_req(12'h102, 4'd0, t);
        repeat (4) tick();
        chk("wburst_readback_cnt", rx1.size(), 1);
        chk("wburst_readback", at_data(rx1, 0), 32'hB000_0102);

        // clken stall in the middle of an 8-beat read burst.
        for (int i = 0; i < 8; i++) wr_req(12'h200, 32'hC000_0200 + i, 4'hF, 4'd8);
        rx1.delete(); rx2.delete();
        rd_req(12'h200, 4'd8, t);
        repeat (2) tick();
        clken = 1'b0;
        repeat (3) tick();
        clken = 1'b1;
        repeat (14) tick();
        chk("stall_count_L1", rx1.size(), 8);
        chk("stall_count_L2", rx2.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("stall_data_L1", at_data(rx1, i), 32'hC000_0200 + i);
            chk("stall_data_L2", at_data(rx2, i), 32'hC000_0200 + i);
        end

        // reset_req blocks acceptance for one cycle while the read is held.
        rx1.delete();
        cs = 1'b1; rd = 1'b1; address = 12'h010; burstcount = 4'd1; reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        tick();
        set_idle();
        repeat (3) tick();
        chk("reset_req_one_beat", rx1.size(), 1);
        chk("reset_req_data", at_data(rx1, 0), 32'hDE22_BE44);

        // Reset two beats into an 8-beat read burst.
        rx1.delete(); rx2.delete();
        rd_req(12'h200, 4'd8, t);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("post_reset_rdv_L1", w1_rdv, 1'b0);
        chk("post_reset_rdv_L2", w2_rdv, 1'b0);
        chk("post_reset_wait", w1_wait, 1'b0);
        repeat (6) tick();
        chk("reset_beats_L1", rx1.size(), 2);
        chk("reset_beats_L2", rx2.size(), 1);
        rd_req(12'h205, 4'd1, t);
        repeat (4) tick();
        chk("reset_mem_kept", at_data(rx1, rx1.size() - 1), 32'hC000_0205);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hps_onchip_burst_memory.md
Name: hps_onchip_burst_memory

Overview:
Parametrised Avalon-MM on-chip RAM slave for the HPS lightweight/FPGA fabric: successor to the fixed 4096x32 single-cycle memory. Adds configurable data width and depth, pipelined reads with `readdatavalid`, and selectable 1- or 2-cycle read latency. Adds incrementing read/write bursts, `waitrequest` flow control, and clock-enable stalling. Sits behind the HPS-to-FPGA bridge interconnect as a scratchpad/boot buffer.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 12, word address width.
- DEPTH, 4096, number of words; must be <= 2**ADDR_WIDTH.
- BURST_WIDTH, 4, burstcount width; max burst = 2**(BURST_WIDTH-1).
- READ_LATENCY, 1, 1 = registered RAM output, 2 = extra output register.
- INIT_FILE, "HPS_onchip_memory.hex", memory initialisation file; contents are not altered by reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- address  in  ADDR_WIDTH  word address (first beat of burst)
- burstcount  in  BURST_WIDTH  beats in burst; 0 treated as 1
- byteenable  in  DATA_WIDTH/8  write byte lanes
- chipselect  in  1  slave select
- read  in  1  read request
- write  in  1  write request/beat
- writedata  in  DATA_WIDTH  write data
- clken  in  1  global clock enable
- reset_req  in  1  reset-request gating; RAM disabled while high
- waitrequest  out  1  transfer not accepted this cycle
- readdata  out  DATA_WIDTH  read data
- readdatavalid  out  1  readdata valid this cycle

Behaviour:
- **Reset and enable**
  - Reset is synchronous, active-high. While reset is high, `waitrequest`=1.
  - Registered outputs after reset:
    - `readdata`=0.
    - `readdatavalid`=0.
    - State IDLE.
    - Latency pipeline cleared; in-flight reads are discarded.
  - en = clken & ~reset_req.
  - When en=0: no state, address, counter or pipeline register changes; `waitrequest`=1.
- **waitrequest**
  - `waitrequest` = reset | ~en | (state==RBURST).
  - A transfer is accepted when chipselect & (read|write) & ~waitrequest.
- **States**
  - IDLE:
    - Accepted write: RAM[address] written under byteenable. If burstcount>1, go to WBURST with rem=burstcount-1 and nxt=address+1.
    - Accepted read: read of address issued. If burstcount>1, go to RBURST with rem=burstcount-1 and nxt=address+1.
    - read and write both high: write wins; read ignored.
  - RBURST:
    - Each en cycle issues a read at nxt; nxt++, rem--.
    - Issuing with rem==1 returns to IDLE the same edge.
    - Master inputs are ignored.
  - WBURST:
    - Each accepted write beat writes writedata at nxt under byteenable; nxt++, rem--.
    - Beat with rem==1 returns to IDLE.
    - Cycles with write=0 are idle (no count).
    - read during WBURST is ignored.
- **Address arithmetic**
  - nxt wraps modulo DEPTH (DEPTH-1 -> 0), not modulo 2**ADDR_WIDTH.
  - Addresses >= DEPTH on a first beat alias modulo DEPTH.
- **Read pipeline**
  - Issued read -> `readdatavalid`=1 exactly READ_LATENCY en-cycles later with the RAM word.
  - Pipeline shifts only when en=1. Stalled beats remain pending, with `readdatavalid` held 0 during the stall.
  - `readdata` holds its last value when `readdatavalid`=0.
- **Read/write ordering**
  - Single-port RAM.
  - A read issued the cycle after a write to the same address returns the new data.
  - No read and write are accepted in the same cycle.
- **Throughput**
  - Back-to-back single reads accepted every cycle.
  - Read burst of N occupies N cycles (waitrequest high for N-1 of them), then `readdatavalid` for N consecutive cycles.

Test Plan:
- **Single write/read, READ_LATENCY=1:** write 0xDEADBEEF to addr 0x010 with be=4'hF, then read 0x010 → `readdatavalid` one cycle after accept, `readdata`=0xDEADBEEF.
- **Byteenable:** write 0x11223344 with be=4'b0101 over 0xDEADBEEF at 0x010 → subsequent read returns 0xDE22BE44.
- **Burst read with wrap, READ_LATENCY=2:** preload words at 0xFFE..0x001, read address 0xFFE burstcount=4 → `waitrequest` high 3 cycles; `readdatavalid` 4 consecutive cycles starting 2 cycles after accept, data in order 0xFFE, 0xFFF, 0x000, 0x001.
- **Write burst with gaps:** write burst of 4 at 0x100 with write deasserted 2 cycles between beats 2 and 3 → words 0x100..0x103 correct; IDLE after 4th beat; next single read at 0x102 is correct.
- **clken stall:** clken=0 for 3 cycles mid read burst of 8 → no address advance, `readdatavalid`=0 during stall; all 8 beats delivered in order, none duplicated.
- **Reset mid burst:** reset after 2 of 8 read beats → `readdatavalid`=0 the cycle after reset; state IDLE; `waitrequest`=0 after reset drops; memory contents unchanged on re-read.
